dbg_retire_trace_fifo: RTL

// Consumes the per-instruction retire/debug record of the RV32I core (pc, op, rd, result, dmem side).

---
 rtl/dbg_retire_trace_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dbg_retire_trace_fifo.sv
// Retire trace buffer: tags each retired instruction with a sequence number and queues it
// for a valid/ready trace sink. The core is never stalled; records that do not fit are counted.
module dbg_retire_trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     retire_valid,
  input  logic [31:0]              retire_pc,
  input  logic [6:0]               retire_op,
  input  logic [4:0]               retire_rd,
  input  logic                     retire_regwrite,
  input  logic [31:0]              retire_result,
  input  logic                     retire_dmem_we,
  input  logic [31:0]              retire_dmem_addr,
  input  logic [31:0]              retire_dmem_wd,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [SEQ_W+142:0]       trace_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = SEQ_W + 143;

  logic [TW-1:0]     mem_q [DEPTH];
  logic [TW-1:0]     mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  logic              gap_pend_q, gap_pend_d;
  logic              trace_valid_q, trace_valid_d;
  logic [TW-1:0]     trace_data_q, trace_data_d;

  logic              capture_s, pop_s, full_s, push_s, drop_s;
  logic [TW-1:0]     entry_s;

  // Push/pop/drop decisions and next-state for every register.
  always_comb begin
    capture_s = en & retire_valid;
    pop_s     = trace_valid_q & trace_ready;
    full_s    = (count_q == CW'(DEPTH));
    push_s    = capture_s & (~full_s | pop_s);
    drop_s    = capture_s & full_s & ~pop_s;
    entry_s   = {seq_q, gap_pend_q, retire_pc, retire_op, retire_rd, retire_regwrite,
                 retire_result, retire_dmem_we, retire_dmem_addr, retire_dmem_wd};

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = entry_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (capture_s) begin
      seq_d = seq_q + SEQ_W'(1);
    end else begin
      seq_d = seq_q;
    end

    if (drop_s && (drop_cnt_q != {DROP_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    // A drop beats a simultaneous clear so no loss can go unreported.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (drop_s) begin
      gap_pend_d = 1'b1;
    end else if (push_s) begin
      gap_pend_d = 1'b0;
    end else begin
      gap_pend_d = gap_pend_q;
    end

    trace_valid_d = (count_d != CW'(0));
    if (trace_valid_d) begin
      trace_data_d = mem_d[rd_ptr_d];
    end else begin
      trace_data_d = {TW{1'b0}};
    end
  end

  // State registers; reset discards all buffered entries at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {TW{1'b0}};
      end
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {CW{1'b0}};
      seq_q         <= {SEQ_W{1'b0}};
      drop_cnt_q    <= {DROP_W{1'b0}};
      overflow_q    <= 1'b0;
      gap_pend_q    <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_data_q  <= {TW{1'b0}};
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      seq_q         <= seq_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
      gap_pend_q    <= gap_pend_d;
      trace_valid_q <= trace_valid_d;
      trace_data_q  <= trace_data_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_data  = trace_data_q;
  assign count       = count_q;
  assign drop_cnt    = drop_cnt_q;
  assign overflow    = overflow_q;

endmodule
